alu_md: RTL and testbench

- Parametrised successor of the single-cycle logic ALU for the MIPS datapath (execute stage).
- Keeps the existing logic/LUI op codes and adds add/sub with overflow, set-less-than and shifts.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake that the hazard unit uses to stall the pipeline.

---
 rtl/alu_md.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_md.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Execute-stage ALU with an iterative multiply/divide unit and HI/LO.
// The mult/div handshake (start/busy/done) feeds the hazard unit.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   sa,
    input  logic [5:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int H = WIDTH / 2;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_OR    = 6'b000100;
    localparam logic [5:0] OP_NOR   = 6'b000101;
    localparam logic [5:0] OP_XOR   = 6'b000110;
    localparam logic [5:0] OP_LUI   = 6'b001010;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTHI  = 6'b010100;
    localparam logic [5:0] OP_MTLO  = 6'b010101;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] dif_ab;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_s;
    logic             lt_u;

    assign sum_ab  = a + b;
    assign dif_ab  = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum_ab[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (dif_ab[WIDTH-1] != a[WIDTH-1]);
    assign lt_s    = $signed(a) < $signed(b);
    assign lt_u    = a < b;

    always_comb begin
        y        = '0;
        overflow = 1'b0;
        case (op)
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_LUI:  y = {b[H-1:0], {H{1'b0}}};
            OP_ADD: begin
                y        = sum_ab;
                overflow = add_ovf;
            end
            OP_ADDU: y = sum_ab;
            OP_SUB: begin
                y        = dif_ab;
                overflow = sub_ovf;
            end
            OP_SUBU: y = dif_ab;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLL:  y = b << sa;
            OP_SRL:  y = b >> sa;
            OP_SRA:  y = $signed(b) >>> sa;
            OP_MFHI: y = hi_q;
            OP_MFLO: y = lo_q;
            default: ;
        endcase
    end

    // One iteration on magnitudes: acc_hi:acc_lo is the product or rem:quo pair.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     r_sh;
    logic               ge;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
        r_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        ge      = r_sh >= {1'b0, m_q};
        if (is_div_q) begin
            step_hi = ge ? WIDTH'(r_sh - {1'b0, m_q}) : r_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = div0_q ? '1 : (neg_q ? -step_lo : step_lo);
        rem_fix  = neg_rem_q ? -step_hi : step_hi;
    end

    logic             md_op;
    logic             accept;
    logic             sgn;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign md_op  = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_DIV)  || (op == OP_DIVU);
    assign accept = start && (state_q != RUN);
    assign sgn    = ~op[0];
    assign sign_a = sgn & a[WIDTH-1];
    assign sign_b = sgn & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        unique case (state_q)
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = FIN;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (accept && md_op) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    acc_lo_d  = mag_a;
                    m_d       = mag_b;
                    is_div_d  = op[1];
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div0_d    = op[1] && (b == '0);
                end
                if (accept && op == OP_MTHI) hi_d = a;
                if (accept && op == OP_MTLO) lo_d = a;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_alu_md.sv
// Randomized bench for alu_md against an arithmetic reference model.
// HI/LO are tracked by the model as operations complete.
module tb_alu_md;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_OR    = 6'b000100;
    localparam logic [5:0] OP_NOR   = 6'b000101;
    localparam logic [5:0] OP_XOR   = 6'b000110;
    localparam logic [5:0] OP_LUI   = 6'b001010;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTHI  = 6'b010100;
    localparam logic [5:0] OP_MTLO  = 6'b010101;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  sa = '0;
    logic [5:0]  op = OP_MFHI;
    logic        start = 1'b0;
    logic [31:0] y;
    logic        overflow;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_md #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sa(sa), .op(op),
        .start(start), .y(y), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_alu(input logic [5:0] o,
        input logic [31:0] av, input logic [31:0] bv, input logic [4:0] s);
        longint sa64, sb64, r64;
        logic [63:0] u64;
        logic [31:0] r;
        logic ov;
        sa64 = longint'($signed(av));
        sb64 = longint'($signed(bv));
        r = '0;
        ov = 1'b0;
        case (o)
            OP_XOR:  r = av ^ bv;
            OP_NOR:  r = ~(av | bv);
            OP_AND:  r = av & bv;
            OP_OR:   r = av | bv;
            OP_LUI:  r = bv * 32'd65536;
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: begin
                r64 = o[1] ? sa64 - sb64 : sa64 + sb64;
                r = r64[31:0];
                ov = !o[0] && (r64 != longint'($signed(r)));
            end
            OP_SLT:  r = (sa64 < sb64) ? 32'd1 : 32'd0;
            OP_SLTU: r = (av < bv) ? 32'd1 : 32'd0;
            OP_SLL: begin
                u64 = {32'b0, bv} << s;
                r = u64[31:0];
            end
            OP_SRL: begin
                u64 = {32'b0, bv} >> s;
                r = u64[31:0];
            end
            OP_SRA: begin
                r64 = sb64 >>> s;
                r = r64[31:0];
            end
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    function automatic logic [63:0] md_ref(input logic [5:0] o,
        input logic [31:0] av, input logic [31:0] bv);
        longint sa64, sb64, q, r;
        logic [63:0] p;
        sa64 = longint'($signed(av));
        sb64 = longint'($signed(bv));
        p = '0;
        case (o)
            OP_MULT:  p = sa64 * sb64;
            OP_MULTU: p = {32'b0, av} * {32'b0, bv};
            default: begin
                if (bv == 0) begin
                    p = {av, 32'hFFFF_FFFF};
                end else if (o == OP_DIV) begin
                    q = sa64 / sb64;
                    r = sa64 % sb64;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {av % bv, av / bv};
                end
            end
        endcase
        return p;
    endfunction

    task automatic comb(input string tag, input logic [5:0] o,
        input logic [31:0] av, input logic [31:0] bv, input logic [4:0] s,
        input logic [32:0] exp);
        op = o; a = av; b = bv; sa = s;
        #1;
        check(tag, {31'b0, overflow, y}, {31'b0, exp});
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] av,
                         input logic [31:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = OP_MFHI;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        op = OP_MFHI; #1; h = y;
        op = OP_MFLO; #1; l = y;
        op = OP_MFHI;
    endtask

    task automatic md_test(input string tag, input logic [5:0] o,
        input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp);
        int lat, bc;
        logic [31:0] h, l;
        issue(o, av, bv);
        wait_done(1, lat, bc);
        read_hl(h, l);
        check({tag, "_lat"}, lat, 33);
        check({tag, "_busy"}, bc, 32);
        check({tag, "_hilo"}, {h, l}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bc, dcnt;
        logic [31:0] h, l, av, bv;
        logic [5:0] o;
        logic [63:0] e;

        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {busy, done}, 2'b00);
        rst = 1'b0;
        read_hl(h, l);
        check("rst_hilo", {h, l}, 64'h0);

        comb("xor", OP_XOR, 32'h0000F0F0, 32'h00FF00FF, 0, {1'b0, 32'h00FFF00F});
        comb("nor", OP_NOR, 32'h0000F0F0, 32'h00FF00FF, 0, {1'b0, 32'hFF000F00});
        comb("and", OP_AND, 32'h0000F0F0, 32'h00FF00FF, 0, {1'b0, 32'h000000F0});
        comb("or", OP_OR, 32'h0000F0F0, 32'h00FF00FF, 0, {1'b0, 32'h00FFF0FF});
        comb("lui", OP_LUI, 32'h0, 32'h1234, 0, {1'b0, 32'h12340000});
        comb("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 0, {1'b1, 32'h80000000});
        comb("addu", OP_ADDU, 32'h7FFFFFFF, 32'h1, 0, {1'b0, 32'h80000000});
        comb("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 0, {1'b1, 32'h7FFFFFFF});
        comb("slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 0, {1'b0, 32'h1});
        comb("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 0, {1'b0, 32'h0});
        comb("sra", OP_SRA, 32'h0, 32'h80000000, 4, {1'b0, 32'hF8000000});
        comb("bad_op", 6'b111111, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 33'h0);

        for (int i = 0; i < 300; i++) begin
            o = 6'($urandom_range(0, 63));
            av = $urandom;
            bv = $urandom;
            if (i % 7 == 0) av = 32'h7FFFFFFF;
            if (i % 11 == 0) bv = 32'h80000000;
            lat = $urandom_range(0, 31);
            comb("rand_comb", o, av, bv, 5'(lat), ref_alu(o, av, bv, 5'(lat)));
        end

        md_test("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
        md_test("multu_max2", OP_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
        md_test("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        md_test("divu_by0", OP_DIVU, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
        md_test("div_minneg", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

        for (int i = 0; i < 24; i++) begin
            lat = $urandom_range(0, 5);
            o = (lat == 4) ? OP_MTHI : (lat == 5) ? OP_MTLO :
                6'(OP_MULT + 6'(lat));
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 5))
                0: bv = 32'd0;
                1: bv = 32'hFFFFFFFF;
                2: bv = 32'($urandom_range(1, 9));
                3: av = 32'h80000000;
                default: ;
            endcase
            if (o == OP_MTHI || o == OP_MTLO) begin
                issue(o, av, bv);
                if (o == OP_MTHI) m_hi = av; else m_lo = av;
                read_hl(h, l);
                check("rand_mt", {busy, done, h, l}, {2'b00, m_hi, m_lo});
            end else begin
                md_test("rand_md", o, av, bv, md_ref(o, av, bv));
            end
        end

        // second start mid-run must be ignored; mfhi shows the old HI
        issue(OP_DIV, 32'hFFFFFF9C, 32'd7);
        #1;
        check("mfhi_busy", y, m_hi);
        repeat (9) begin
            @(posedge clk); #1;
        end
        op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = OP_MFHI;
        wait_done(11, lat, bc);
        check("ign_lat", lat, 33);
        read_hl(h, l);
        e = md_ref(OP_DIV, 32'hFFFFFF9C, 32'd7);
        check("ign_hilo", {h, l}, e);

        // start accepted while in FIN
        issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
        check("fin_accept", {busy, done}, 2'b10);
        wait_done(1, lat, bc);
        check("fin_lat", lat, 33);
        read_hl(h, l);
        check("fin_hilo", {h, l}, md_ref(OP_MULTU, 32'h12345678, 32'h9ABCDEF0));

        @(posedge clk); #1;
        issue(OP_MULT, 32'd12345, 32'hFFFFFD5A);
        repeat (14) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_flags", {busy, done}, 2'b00);
        read_hl(h, l);
        check("abort_hilo", {h, l}, 64'h0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        m_hi = '0;
        m_lo = '0;

        issue(OP_MTHI, 32'hA5A5A5A5, 32'h0);
        #1;
        check("mthi", {busy, done, y}, {2'b00, 32'hA5A5A5A5});
        issue(OP_MTLO, 32'h5A5A5A5A, 32'h0);
        read_hl(h, l);
        check("mtlo", {h, l}, 64'hA5A5A5A5_5A5A5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
